// File: rtl/pll_drp_reconfig.sv
// DRP read-modify-write sequencer for a PLLE2_ADV: holds the PLL in reset while
// host entries are applied, then releases reset and waits for re-lock.
module pll_drp_reconfig #(
    parameter int RST_HOLD     = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_addr,
    input  logic [15:0] req_data,
    input  logic [15:0] req_mask,
    input  logic        req_last,
    output logic        busy,
    output logic        locked,
    output logic        done,
    output logic        err,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        pll_rst,
    input  logic        pll_locked
);

    localparam int CNT_A   = (DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD;
    localparam int CNT_MAX = (LOCK_TIMEOUT > CNT_A) ? LOCK_TIMEOUT : CNT_A;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_END  = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DRDY_END  = CW'(DRDY_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_END  = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_RD,
        WRITE,
        WAIT_WR,
        NEXT,
        RELEASE,
        WAIT_LOCK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   ent_data;
    logic [15:0]   ent_mask;
    logic          ent_last;
    logic          host_seq;
    logic          sync_meta;

    // host_seq remembers whether the current RELEASE/WAIT_LOCK pass belongs to a
    // host sequence, so the boot-time lock sequence finishes without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RELEASE;
            cnt       <= '0;
            ent_data  <= '0;
            ent_mask  <= '0;
            ent_last  <= 1'b0;
            host_seq  <= 1'b0;
            sync_meta <= 1'b0;
            locked    <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            drp_daddr <= '0;
            drp_den   <= 1'b0;
            drp_dwe   <= 1'b0;
            drp_di    <= '0;
            pll_rst   <= 1'b1;
        end else begin
            sync_meta <= pll_locked;
            locked    <= sync_meta;
            drp_den   <= 1'b0;
            drp_dwe   <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE, NEXT: begin
                    if (req_valid && req_ready) begin
                        if (state == IDLE) begin
                            err      <= 1'b0;
                            host_seq <= 1'b1;
                        end
                        ent_data  <= req_data;
                        ent_mask  <= req_mask;
                        ent_last  <= req_last;
                        drp_daddr <= req_addr;
                        drp_den   <= 1'b1;
                        pll_rst   <= 1'b1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= READ;
                    end
                end

                READ: begin
                    cnt   <= '0;
                    state <= WAIT_RD;
                end

                WAIT_RD: begin
                    if (drp_drdy) begin
                        drp_di  <= (drp_do & ent_mask) | (ent_data & ~ent_mask);
                        drp_den <= 1'b1;
                        drp_dwe <= 1'b1;
                        state   <= WRITE;
                    end else if (cnt == DRDY_END) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WRITE: begin
                    cnt   <= '0;
                    state <= WAIT_WR;
                end

                WAIT_WR: begin
                    if (drp_drdy) begin
                        cnt <= '0;
                        if (ent_last) begin
                            state <= RELEASE;
                        end else begin
                            req_ready <= 1'b1;
                            state     <= NEXT;
                        end
                    end else if (cnt == DRDY_END) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RELEASE: begin
                    if (cnt == HOLD_END) begin
                        pll_rst <= 1'b0;
                        cnt     <= '0;
                        state   <= WAIT_LOCK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_LOCK: begin
                    if (locked || cnt == LOCK_END) begin
                        if (!locked) begin
                            err <= 1'b1;
                        end
                        done      <= host_seq;
                        host_seq  <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
